// File: rtl/bcd_updown_counter_if.sv
// Control and status bundle between the 1 Hz domain logic and the BCD counter.
interface bcd_updown_counter_if #(
  parameter int unsigned DIGITS = 2
);
  localparam int unsigned W = 4 * DIGITS;

  logic         en;
  logic         dir;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] count_bcd;
  logic         at_max;
  logic         at_min;
  logic         wrap;
  logic         load_err;

  // Controller side: drives the controls, observes the count and flags.
  modport master (
    output en, dir, load, load_val,
    input  count_bcd, at_max, at_min, wrap, load_err
  );

  // Counter side.
  modport slave (
    input  en, dir, load, load_val,
    output count_bcd, at_max, at_min, wrap, load_err
  );
endinterface

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with programmable modulus, load and wrap/saturate.
module bcd_updown_counter #(
  parameter int unsigned DIGITS   = 2,
  parameter int unsigned MODULUS  = 60,
  parameter bit          SATURATE = 1'b0
) (
  input  logic                 clk_1Hz,
  input  logic                 reset,
  bcd_updown_counter_if.slave  bus
);

  localparam int unsigned W = 4 * DIGITS;

  // Packs an integer into BCD, digit 0 in the low nibble.
  function automatic logic [W-1:0] to_bcd(input int unsigned v);
    logic [W-1:0] r;
    int unsigned  t;
    r = '0;
    t = v;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int unsigned pow10(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  // Ripple BCD increment: a digit advances only when every lower digit rolled 9->0.
  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic [3:0]   d;
    logic         carry;
    r     = v;
    carry = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      d = v[4*i +: 4];
      if (carry) begin
        if (d == 4'd9) begin
          d = 4'd0;
        end else begin
          d     = d + 4'd1;
          carry = 1'b0;
        end
      end
      r[4*i +: 4] = d;
    end
    return r;
  endfunction

  // Ripple BCD decrement: a digit drops only when every lower digit rolled 0->9.
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic [3:0]   d;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      d = v[4*i +: 4];
      if (borrow) begin
        if (d == 4'd0) begin
          d = 4'd9;
        end else begin
          d      = d - 4'd1;
          borrow = 1'b0;
        end
      end
      r[4*i +: 4] = d;
    end
    return r;
  endfunction

  // Top of range in BCD; packed BCD compares correctly as unsigned once digits are valid.
  localparam logic [W-1:0] MAX_BCD = to_bcd(MODULUS - 1);

  // Reject illegal parameterisations at elaboration.
  if (DIGITS < 1 || DIGITS > 4) begin : g_bad_digits
    $error("bcd_updown_counter: DIGITS out of range");
  end
  if (MODULUS < 2 || MODULUS > pow10(DIGITS)) begin : g_bad_modulus
    $error("bcd_updown_counter: MODULUS out of range");
  end

  logic [W-1:0] count_q, count_d;
  logic         max_q, max_d;
  logic         min_q, min_d;
  logic         wrap_q, wrap_d;
  logic         err_q, err_d;
  logic         digits_ok;
  logic         load_ok;

  // Load value must be well-formed BCD and inside the count range.
  always_comb begin
    digits_ok = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bus.load_val[4*i +: 4] > 4'd9) digits_ok = 1'b0;
    end
    load_ok = digits_ok && (bus.load_val <= MAX_BCD);
  end

  // Next value and flags: load beats enable; end-of-range wraps or saturates.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    if (bus.load) begin
      if (load_ok) count_d = bus.load_val;
      else         err_d   = 1'b1;
    end else if (bus.en) begin
      if (!bus.dir) begin
        if (count_q == MAX_BCD) begin
          if (!SATURATE) begin
            count_d = '0;
            wrap_d  = 1'b1;
          end
        end else begin
          count_d = bcd_inc(count_q);
        end
      end else begin
        if (count_q == '0) begin
          if (!SATURATE) begin
            count_d = MAX_BCD;
            wrap_d  = 1'b1;
          end
        end else begin
          count_d = bcd_dec(count_q);
        end
      end
    end
    max_d = (count_d == MAX_BCD);
    min_d = (count_d == '0);
  end

  // State and status registers; flags are registered alongside the count.
  always_ff @(posedge clk_1Hz or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      max_q   <= 1'b0;
      min_q   <= 1'b1;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      max_q   <= max_d;
      min_q   <= min_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign bus.count_bcd = count_q;
  assign bus.at_max    = max_q;
  assign bus.at_min    = min_q;
  assign bus.wrap      = wrap_q;
  assign bus.load_err  = err_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Bench for bcd_updown_counter: three configurations driven from one vector table.
module tb_bcd_updown_counter;

  logic clk_1Hz = 1'b0;
  always #5 clk_1Hz = ~clk_1Hz;

  logic rst_a, rst_b, rst_c;

  bcd_updown_counter_if #(.DIGITS(2)) if_a ();
  bcd_updown_counter_if #(.DIGITS(2)) if_b ();
  bcd_updown_counter_if #(.DIGITS(1)) if_c ();

  // 0: mod-60 wrapping, 1: mod-60 saturating, 2: legacy single-digit mod-6.
  bcd_updown_counter #(.DIGITS(2), .MODULUS(60), .SATURATE(1'b0)) dut_a (
    .clk_1Hz(clk_1Hz), .reset(rst_a), .bus(if_a.slave));
  bcd_updown_counter #(.DIGITS(2), .MODULUS(60), .SATURATE(1'b1)) dut_b (
    .clk_1Hz(clk_1Hz), .reset(rst_b), .bus(if_b.slave));
  bcd_updown_counter #(.DIGITS(1), .MODULUS(6), .SATURATE(1'b0)) dut_c (
    .clk_1Hz(clk_1Hz), .reset(rst_c), .bus(if_c.slave));

  typedef struct {
    int          dut;
    logic        en;
    logic        dir;
    logic        load;
    logic [7:0]  lv;
    logic [11:0] exp;
  } vec_t;

  typedef struct {
    int          dut;
    int          idx;
    logic [11:0] exp;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb_q[$];
  int   model_val[3];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic int mod_of(input int d);
    return (d == 2) ? 6 : 60;
  endfunction

  function automatic bit sat_of(input int d);
    return (d == 1);
  endfunction

  // Expected outputs packed as {count[7:0], at_max, at_min, wrap, load_err}.
  function automatic logic [11:0] pack_exp(input int d, input int val, input logic w, input logic e);
    logic [7:0] bcd;
    bcd = {4'(val / 10), 4'(val % 10)};
    return {bcd, (val == mod_of(d) - 1), (val == 0), w, e};
  endfunction

  // Integer reference model; appends one vector with its expected result.
  task automatic add(input int d, input logic en, input logic dir, input logic load, input logic [7:0] lv);
    int   m, v, d0, d1;
    logic w, e;
    m  = mod_of(d);
    v  = model_val[d];
    w  = 1'b0;
    e  = 1'b0;
    d0 = int'(lv[3:0]);
    d1 = int'(lv[7:4]);
    if (load) begin
      if (d0 > 9 || d1 > 9 || d1 * 10 + d0 >= m) e = 1'b1;
      else v = d1 * 10 + d0;
    end else if (en) begin
      if (!dir) begin
        if (v == m - 1) begin
          if (!sat_of(d)) begin v = 0; w = 1'b1; end
        end else v = v + 1;
      end else begin
        if (v == 0) begin
          if (!sat_of(d)) begin v = m - 1; w = 1'b1; end
        end else v = v - 1;
      end
    end
    model_val[d] = v;
    vecs.push_back('{d, en, dir, load, lv, pack_exp(d, v, w, e)});
  endtask

  task automatic idle_all();
    if_a.en = 1'b0; if_a.dir = 1'b0; if_a.load = 1'b0; if_a.load_val = '0;
    if_b.en = 1'b0; if_b.dir = 1'b0; if_b.load = 1'b0; if_b.load_val = '0;
    if_c.en = 1'b0; if_c.dir = 1'b0; if_c.load = 1'b0; if_c.load_val = '0;
  endtask

  task automatic drive(input int d, input logic en, input logic dir, input logic load, input logic [7:0] lv);
    idle_all();
    case (d)
      0:       begin if_a.en = en; if_a.dir = dir; if_a.load = load; if_a.load_val = lv; end
      1:       begin if_b.en = en; if_b.dir = dir; if_b.load = load; if_b.load_val = lv; end
      default: begin if_c.en = en; if_c.dir = dir; if_c.load = load; if_c.load_val = lv[3:0]; end
    endcase
  endtask

  function automatic logic [11:0] observe(input int d);
    case (d)
      0:       return {if_a.count_bcd, if_a.at_max, if_a.at_min, if_a.wrap, if_a.load_err};
      1:       return {if_b.count_bcd, if_b.at_max, if_b.at_min, if_b.wrap, if_b.load_err};
      default: return {4'h0, if_c.count_bcd, if_c.at_max, if_c.at_min, if_c.wrap, if_c.load_err};
    endcase
  endfunction

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got count=%h max=%b min=%b wrap=%b err=%b, want count=%h max=%b min=%b wrap=%b err=%b",
               name, act[11:4], act[3], act[2], act[1], act[0], exp[11:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  initial begin
    sb_t s;

    // Table: multi-digit wrap, borrow, rejected loads, hold, load priority, saturate, legacy mod-6.
    model_val[0] = 0; model_val[1] = 0; model_val[2] = 0;
    for (int i = 0; i < 61; i++) add(0, 1'b1, 1'b0, 1'b0, 8'h00);
    add(0, 1'b0, 1'b0, 1'b1, 8'h10);
    for (int i = 0; i < 12; i++) add(0, 1'b1, 1'b1, 1'b0, 8'h00);
    add(0, 1'b0, 1'b0, 1'b1, 8'h7A);
    add(0, 1'b0, 1'b0, 1'b1, 8'h65);
    add(0, 1'b0, 1'b0, 1'b1, 8'h42);
    for (int i = 0; i < 5; i++) add(0, 1'b0, 1'(i % 2), 1'b0, 8'h00);
    add(0, 1'b1, 1'b0, 1'b1, 8'h30);
    add(1, 1'b0, 1'b0, 1'b1, 8'h58);
    for (int i = 0; i < 3; i++) add(1, 1'b1, 1'b0, 1'b0, 8'h00);
    add(1, 1'b0, 1'b0, 1'b1, 8'h01);
    for (int i = 0; i < 3; i++) add(1, 1'b1, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 6; i++) add(2, 1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 2; i++) add(2, 1'b1, 1'b1, 1'b0, 8'h00);

    idle_all();
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    #1;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    #1;
    check("reset_a", observe(0), pack_exp(0, 0, 1'b0, 1'b0));
    check("reset_b", observe(1), pack_exp(1, 0, 1'b0, 1'b0));
    check("reset_c", observe(2), pack_exp(2, 0, 1'b0, 1'b0));
    #6;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].dut, vecs[i].en, vecs[i].dir, vecs[i].load, vecs[i].lv);
      sb_q.push_back('{vecs[i].dut, i, vecs[i].exp});
      @(posedge clk_1Hz);
      #1;
      s = sb_q.pop_front();
      check($sformatf("vec%0d_dut%0d", s.idx, s.dut), observe(s.dut), s.exp);
    end

    // Asynchronous reset in the middle of a cycle while counting.
    drive(0, 1'b0, 1'b0, 1'b1, 8'h37);
    @(posedge clk_1Hz);
    #1;
    check("load_37", observe(0), {8'h37, 1'b0, 1'b0, 1'b0, 1'b0});
    drive(0, 1'b1, 1'b0, 1'b0, 8'h00);
    #3;
    rst_a = 1'b1;
    #1;
    check("async_reset", observe(0), {8'h00, 1'b0, 1'b1, 1'b0, 1'b0});
    @(posedge clk_1Hz);
    #1;
    check("reset_held", observe(0), {8'h00, 1'b0, 1'b1, 1'b0, 1'b0});
    #2;
    rst_a = 1'b0;
    @(posedge clk_1Hz);
    #1;
    check("resume_01", observe(0), {8'h01, 1'b0, 1'b0, 1'b0, 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_updown_counter.md
Name: bcd_updown_counter

Overview:
- Parametrised successor to the board's single-digit mod-6 Moore up/down counter.
- Multi-digit BCD counter with programmable modulus, direction control, count enable, synchronous parallel load and a wrap-or-saturate mode.
- Registered status flags included.
- Sits between the 1 Hz divider and per-digit dec7seg instances. Typical use: seconds/minutes display on HEX0..HEXn.

Parameters:
- DIGITS, 2, number of BCD digits. Legal range 1..4.
- MODULUS, 60, count range 0..MODULUS-1. Legal range 2 <= MODULUS <= 10^DIGITS.
- SATURATE, 0, end-of-range action. 0 = wrap around; 1 = hold at the end value.

Ports:
- clk_1Hz, input, 1, counting clock (1 Hz tick from the frequency divider).
- reset, input, 1, asynchronous, active-high; clock clk_1Hz.
- en, input, 1, count enable. Sampled on the rising edge of clk_1Hz.
- dir, input, 1, count direction. 0 = up, 1 = down.
- load, input, 1, synchronous load strobe.
- load_val, input, 4*DIGITS, packed BCD load value. Digit 0 in bits [3:0].
- count_bcd, output, 4*DIGITS, current value as packed BCD. Registered.
- at_max, output, 1, high while value == MODULUS-1. Registered (Moore output).
- at_min, output, 1, high while value == 0. Registered (Moore output).
- wrap, output, 1, one-cycle pulse in the cycle after a wrap transition.
- load_err, output, 1, one-cycle pulse in the cycle after a rejected load.

Behaviour:
- Reset (async, asserted at any time, including mid-count):
  - count_bcd = 0, at_min = 1, at_max = 0, wrap = 0, load_err = 0.
  - Takes effect immediately, without waiting for a clock edge.
- Priority per clk_1Hz edge: reset > load > en. With en = 0 and load = 0 the value holds and the pulse outputs clear.
- Load:
  - Accepted when every digit of load_val is <= 9 and its value is < MODULUS. count_bcd = load_val on the next edge.
  - Otherwise count_bcd is unchanged and load_err = 1 for one cycle.
  - A load overrides en/dir in the same cycle and never produces a wrap pulse.
- Up count (en = 1, dir = 0):
  - Value < MODULUS-1: value + 1.
  - Value == MODULUS-1 and SATURATE = 0: value becomes 0 and wrap pulses.
  - Value == MODULUS-1 and SATURATE = 1: value holds and wrap stays 0.
- Down count (en = 1, dir = 1):
  - Value > 0: value - 1.
  - Value == 0 and SATURATE = 0: value becomes MODULUS-1 and wrap pulses.
  - Value == 0 and SATURATE = 1: value holds.
- BCD arithmetic:
  - Digit i increments only when all lower digits are 9 (up), and decrements only when all lower digits are 0 (down).
  - A digit rolls 9->0 when counting up and 0->9 when counting down.
  - The modulus check uses the full BCD value, not per-digit values. Example: MODULUS = 60 gives 59 -> 00, never 59 -> 60.
  - Digits never hold values above 9 after reset.
- dir may change on any edge: the new direction applies from that edge. There is no intermediate state.
- Latency:
  - count_bcd updates one clk_1Hz edge after en/load is sampled.
  - at_max and at_min are decoded from the registered state and valid in the same cycle as count_bcd.
  - wrap and load_err are registered and coincide with the updated count_bcd.

Test Plan (DIGITS = 2, MODULUS = 60, SATURATE = 0 unless stated):
- Reset then en = 1, dir = 0 for 61 edges -> count goes 00, 01 ... 09, 10 ... 59, 00, 01. wrap is high only in the cycle showing 00 after 59. at_max is high only while 59.
- Load 0x10, then dir = 1 for 12 edges -> count goes 10, 09 ... 00, 59, 58. The digit borrow occurs at 10 -> 09. wrap pulses at 00 -> 59.
- Load 0x7A (invalid digit), then load 0x65 (>= MODULUS) -> count unchanged and load_err pulses twice. Load 0x42 -> count = 42 with no load_err.
- SATURATE = 1: load 0x58, then up 3 edges -> 59, 59, 59 with wrap never asserted. Then down from 01 for 3 edges -> 00, 00, 00 with at_min = 1.
- en = 0 with dir toggling for 5 edges -> count held. Then load = 1 and en = 1 with load_val = 0x30 on the same edge -> count = 30 (load wins), not 31.
- Assert reset asynchronously between edges while count = 37 and en = 1 -> count_bcd = 00 immediately, at_min = 1. After release, counting resumes at 01 on the next edge.
- DIGITS = 1, MODULUS = 6 -> up sequence 0..5, 0 and down sequence 0, 5, 4, matching the legacy mod-6 counter.
